// File: rtl/booth_mul_pkg.sv
// Shared constants, state/op encodings and the radix-4 Booth window decode
// for the iterative signed 16x16 multiplier.
package booth_mul_pkg;

    localparam int unsigned WIDTH  = 16;            // operand width, must be even
    localparam int unsigned PROD_W = 2 * WIDTH;     // product width
    localparam int unsigned ITER   = WIDTH / 2;     // one bit-pair retired per clock
    localparam int unsigned A_W    = WIDTH + 2;     // accumulator holds +/-2M without overflow
    localparam int unsigned Q_W    = WIDTH + 1;     // multiplier plus the implicit y[-1] bit
    localparam int unsigned CNT_W  = $clog2(ITER);

    typedef enum logic {
        IDLE,
        CALC
    } state_e;

    typedef enum logic [2:0] {
        PP_ZERO,
        PP_POS1,
        PP_POS2,
        PP_NEG1,
        PP_NEG2
    } booth_op_e;

    // Radix-4 Booth recoding of the window {y[i+1], y[i], y[i-1]}
    function automatic booth_op_e booth_decode(input logic [2:0] w);
        booth_op_e op;
        case (w)
            3'b001, 3'b010: op = PP_POS1;
            3'b011:         op = PP_POS2;
            3'b100:         op = PP_NEG2;
            3'b101, 3'b110: op = PP_NEG1;
            default:        op = PP_ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Combinational radix-4 Booth partial-product generator.
// Ports:
//   window  3-bit Booth window Q[2:0]
//   m       sign-extended multiplicand (A_W bits)
//   pp_c    selected partial product: 0, +M, +2M, -M or -2M (A_W bits)
module booth_r4_encoder
    import booth_mul_pkg::*;
(
    input  logic [2:0]     window,
    input  logic [A_W-1:0] m,
    output logic [A_W-1:0] pp_c
);

    booth_op_e      op_c;
    logic [A_W-1:0] m2_c;

    // 2M; m carries two sign bits so the shift cannot overflow
    assign m2_c = {m[A_W-2:0], 1'b0};

    always_comb begin
        pp_c = '0;
        op_c = booth_decode(window);
        case (op_c)
            PP_POS1: pp_c = m;
            PP_POS2: pp_c = m2_c;
            PP_NEG1: pp_c = A_W'(-m);
            PP_NEG2: pp_c = A_W'(-m2_c);
            default: pp_c = '0;
        endcase
    end

endmodule

// File: rtl/booth_multiplier16.sv
// Iterative signed 16x16 radix-4 Booth multiplier, 8 iteration cycles per product.
// Optional build macro BOOTH_MUL_ZERO_SKIP_EN: a zero operand completes in one
// cycle without entering CALC.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       multiply request, sampled when idle
//   real_x      signed multiplicand
//   real_y      signed multiplier
//   busy        high while iterating
//   done        one-cycle completion pulse
//   product     signed 32-bit product, held until the next completion
module booth_multiplier16
    import booth_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  real_x,
    input  logic [WIDTH-1:0]  real_y,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [A_W-1:0]   a_q, m_q;
    logic [Q_W-1:0]   q_q;

    logic [A_W-1:0]   pp_c, a_sum_c, a_sh_c;
    logic [Q_W-1:0]   q_sh_c;
    logic             zero_c, load_c, skip_c, step_c, last_c;

`ifdef BOOTH_MUL_ZERO_SKIP_EN
    assign zero_c = (real_x == '0) || (real_y == '0);
`else
    assign zero_c = 1'b0;
`endif

    booth_r4_encoder u_encoder (
        .window (q_q[2:0]),
        .m      (m_q),
        .pp_c   (pp_c)
    );

    // Accumulate, then arithmetic shift {A,Q} right by two
    assign a_sum_c          = a_q + pp_c;
    assign {a_sh_c, q_sh_c} = {{2{a_sum_c[A_W-1]}}, a_sum_c, q_q[Q_W-1:2]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && !zero_c) state_d = CALC;
            CALC: if (count_q == CNT_W'(ITER - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath control strobes
    always_comb begin
        load_c = 1'b0;
        skip_c = 1'b0;
        step_c = 1'b0;
        last_c = 1'b0;
        case (state_q)
            IDLE: begin
                load_c = start && !zero_c;
                skip_c = start && zero_c;
            end
            CALC: begin
                step_c = 1'b1;
                last_c = (count_q == CNT_W'(ITER - 1));
            end
            default: ;
        endcase
    end

    // Operand, accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= last_c || skip_c;
            if (load_c) begin
                m_q     <= {{(A_W - WIDTH){real_x[WIDTH-1]}}, real_x};
                q_q     <= {real_y, 1'b0};
                a_q     <= '0;
                count_q <= '0;
                busy    <= 1'b1;
            end else if (step_c) begin
                a_q     <= a_sh_c;
                q_q     <= q_sh_c;
                count_q <= count_q + CNT_W'(1);
            end
            if (last_c) begin
                // High half sits in A, low half in Q[16:1]
                product <= PROD_W'({a_sh_c, q_sh_c[Q_W-1:1]});
                busy    <= 1'b0;
            end else if (skip_c) begin
                product <= '0;
            end
        end
    end

endmodule

// File: tb/tb_booth_multiplier16.sv
// Directed self-checking bench for booth_multiplier16.
module tb_booth_multiplier16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] real_x;
    logic [15:0] real_y;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    // Edges counted after the sampling edge E0 until done is seen
    localparam int LAT_FULL = 8;
`ifdef BOOTH_MUL_ZERO_SKIP_EN
    localparam int LAT_ZERO = 0;
`else
    localparam int LAT_ZERO = 8;
`endif

    booth_multiplier16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .real_x  (real_x),
        .real_y  (real_y),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one multiply, scramble operands after E0, wait (bounded) for done
    task automatic run_mul(input logic [15:0] x, input logic [15:0] y,
                           output logic [31:0] p, output int lat);
        @(negedge clk);
        real_x = x;
        real_y = y;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        real_x = 16'h1234;
        real_y = 16'hA5A5;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        p = product;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        real_x = '0;
        real_y = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (product !== 32'h0) begin n_fail++; $display("FAIL reset_product: got %h expected 00000000", product); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [15:0] xs  [12] = '{16'h0002, 16'hFFFF, 16'hFFF6, 16'h029D, 16'h03E4, 16'hFF61,
                                  16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h1234, 16'h7FFF};
        logic [15:0] ys  [12] = '{16'h0003, 16'h0003, 16'hFFF1, 16'h03E4, 16'h029D, 16'h0058,
                                  16'h8000, 16'h8000, 16'hFFFF, 16'h006F, 16'h0000, 16'h7FFF};
        logic [31:0] exp [12] = '{32'h0000_0006, 32'hFFFF_FFFD, 32'h0000_0096, 32'h000A_2AD4,
                                  32'h000A_2AD4, 32'hFFFF_C958, 32'h4000_0000, 32'hC000_8000,
                                  32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h3FFF_0001};
        logic [31:0] p;
        int lat;
        int exp_lat;
        for (int i = 0; i < 12; i++) begin
            run_mul(xs[i], ys[i], p, lat);
            exp_lat = (xs[i] == 16'h0 || ys[i] == 16'h0) ? LAT_ZERO : LAT_FULL;
            n_checks++;
            if (p !== exp[i]) begin
                n_fail++;
                $display("FAIL product_%0d (%h*%h): got %h expected %h", i, xs[i], ys[i], p, exp[i]);
            end
            n_checks++;
            if (lat !== exp_lat) begin
                n_fail++;
                $display("FAIL latency_%0d: got %0d expected %0d", i, lat, exp_lat);
            end
            // done is a single-cycle pulse
            @(posedge clk);
            #1;
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_%0d: got %b expected 0", i, done); end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        // previous product from the vector run is 3FFF0001
        @(negedge clk);
        real_x = 16'h0002;
        real_y = 16'h0003;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b expected 1", busy); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        real_x = 16'h0007;
        real_y = 16'h0007;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (product !== 32'h3FFF_0001) begin n_fail++; $display("FAIL product_held_busy: got %h expected 3fff0001", product); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_while_busy: got %b expected 0", done); end
        lat = 3;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat !== LAT_FULL) begin n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", lat, LAT_FULL); end
        n_checks++;
        if (product !== 32'h0000_0006) begin n_fail++; $display("FAIL ignore_product: got %h expected 00000006", product); end
        // the ignored request must not have been queued
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || product !== 32'h0000_0006) begin
            n_fail++;
            $display("FAIL no_queue: got busy=%b product=%h expected busy=0 product=00000006", busy, product);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        @(negedge clk);
        real_x = 16'h029D;
        real_y = 16'h03E4;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (product !== 32'h0) begin n_fail++; $display("FAIL midreset_product: got %h expected 00000000", product); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", seen_done); end
        n_checks++;
        if (product !== 32'h0) begin n_fail++; $display("FAIL midreset_hold: got %h expected 00000000", product); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p1;
        int lat;
        run_mul(16'hFFF6, 16'hFFF1, p1, lat);
        n_checks++;
        if (p1 !== 32'h0000_0096) begin n_fail++; $display("FAIL b2b_first: got %h expected 00000096", p1); end
        // still inside the done cycle: issue the next request
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_in_done_cycle: got %b expected 1", done); end
        real_x = 16'hFF61;
        real_y = 16'h0058;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accepted: got %b expected 1", busy); end
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat !== LAT_FULL) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT_FULL); end
        n_checks++;
        if (product !== 32'hFFFF_C958) begin n_fail++; $display("FAIL b2b_second: got %h expected ffffc958", product); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
